pipe_addsub_seg: RTL and testbench

//  Parametrised pipelined adder/subtractor: WIDTH-bit operands split into SEG_W-bit

---
 rtl/pipe_addsub_seg_if.sv | 31 +++
 rtl/pipe_addsub_seg.sv | 121 ++++++++++++
 tb/tb_pipe_addsub_seg.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_seg_if.sv
// Operand/result stream bundle for the segmented pipelined adder/subtractor.
interface pipe_addsub_seg_if #(
    parameter int unsigned WIDTH = 16
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The arithmetic unit itself
    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_addsub_seg.sv
// Pipelined adder/subtractor: one SEG_W-bit ripple segment resolved per stage,
// carry registered between stages, global-stall valid/ready stream handshake.
module pipe_addsub_seg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_addsub_seg_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / SEG_W;
    localparam int unsigned LAST   = STAGES - 1;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEG_W:0]   seg_t;

    // Reject geometries that cannot be split into whole segments
    if (SEG_W == 0 || WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_params
        $error("pipe_addsub_seg: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Per-stage slot: valid, A, mapped B', partial sum so far, carry into next segment
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    word_t             a_q  [STAGES];
    word_t             a_d  [STAGES];
    word_t             bp_q [STAGES];
    word_t             bp_d [STAGES];
    word_t             s_q  [STAGES];
    word_t             s_d  [STAGES];
    logic              ovf_q, ovf_d;

    logic              adv_c;
    word_t             in_a_c;
    word_t             in_bp_c;
    logic              in_c0_c;
    logic [WIDTH:0]    seg_c;

    // Resolve segment k of fa + fb + fc and merge it into partial sum fs; returns {carry, sum}
    function automatic logic [WIDTH:0] seg_add(
        input word_t       fa,
        input word_t       fb,
        input word_t       fs,
        input logic        fc,
        input int unsigned k
    );
        seg_t  r;
        word_t s;
        r = seg_t'(fa[k*SEG_W +: SEG_W]) + seg_t'(fb[k*SEG_W +: SEG_W]) + seg_t'(fc);
        s = fs;
        s[k*SEG_W +: SEG_W] = r[SEG_W-1:0];
        return {r[SEG_W], s};
    endfunction

    // Operand mapping: subtraction is A + ~B + ~borrow; idle slots load zeros so no X reaches the output
    always_comb begin
        in_a_c  = bus.in_valid ? bus.a : '0;
        in_bp_c = '0;
        if (bus.in_valid) begin
            in_bp_c = bus.sub ? ~bus.b : bus.b;
        end
        in_c0_c = bus.in_valid & (bus.sub ^ bus.cin);
    end

    // Global advance and next state of every stage; whole pipe holds when the result is stalled
    always_comb begin
        adv_c   = ~rst_n | bus.out_ready | ~valid_q[LAST];
        valid_d = valid_q;
        carry_d = carry_q;
        a_d     = a_q;
        bp_d    = bp_q;
        s_d     = s_q;
        seg_c   = '0;
        if (adv_c) begin
            seg_c      = seg_add(in_a_c, in_bp_c, '0, in_c0_c, 0);
            valid_d[0] = bus.in_valid;
            a_d[0]     = in_a_c;
            bp_d[0]    = in_bp_c;
            s_d[0]     = seg_c[WIDTH-1:0];
            carry_d[0] = seg_c[WIDTH];
            for (int unsigned k = 1; k < STAGES; k++) begin
                seg_c      = seg_add(a_q[k-1], bp_q[k-1], s_q[k-1], carry_q[k-1], k);
                valid_d[k] = valid_q[k-1];
                a_d[k]     = a_q[k-1];
                bp_d[k]    = bp_q[k-1];
                s_d[k]     = seg_c[WIDTH-1:0];
                carry_d[k] = seg_c[WIDTH];
            end
        end
        // Signed overflow of A + B' + c0, evaluated as the slot enters the output stage
        ovf_d = (a_d[LAST][WIDTH-1] == bp_d[LAST][WIDTH-1]) &
                (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    end

    // Stage registers with synchronous active-low reset; in-flight work is discarded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bp_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            s_q     <= s_d;
        end
    end

    assign bus.in_ready  = adv_c;
    assign bus.out_valid = valid_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = carry_q[LAST];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_addsub_seg.sv
// Bench for pipe_addsub_seg: directed vector table, stall/reset sequences and
// random traffic checked against an integer-arithmetic reference model.
module tb_pipe_addsub_seg;
    localparam int unsigned W      = 16;
    localparam int unsigned SEG    = 4;
    localparam int unsigned STAGES = W / SEG;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_addsub_seg_if #(.WIDTH(W)) bus ();
    pipe_addsub_seg_if #(.WIDTH(5)) bus5 ();

    pipe_addsub_seg #(.WIDTH(W), .SEG_W(SEG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_addsub_seg #(.WIDTH(5), .SEG_W(5))   dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
        int          st;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          pops = 0;
    logic        held = 1'b0;
    logic [15:0] h_sum;
    logic        h_cout, h_ovf;
    logic [15:0] last_sum;
    logic        last_cout, last_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer result, carry/no-borrow and signed range test
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic c,
                                  output logic [15:0] r, output logic co, output logic ov);
        int ua, ub, sa, sb, ci, res, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = c ? 1 : 0;
        if (!s) begin
            res  = ua + ub + ci;
            co   = (res > 65535);
            sres = sa + sb + ci;
        end else begin
            res  = ua - ub - ci;
            co   = (res >= 0);
            sres = sa - sb - ci;
        end
        r  = 16'(res);
        ov = (sres > 32767) || (sres < -32768);
    endfunction

    // One clock: drive inputs just after negedge, check handshake/scoreboard, wait next negedge
    task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic isub, input logic icin, input logic ordy, output logic acc);
        logic        exp_rdy;
        exp_t        e;
        logic [15:0] r;
        logic        co, ov;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.sub       = isub;
        bus.cin       = icin;
        bus.out_ready = ordy;
        #1;
        exp_rdy = ordy | ~bus.out_valid;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (held) begin
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_sum", 32'(bus.sum), 32'(h_sum));
            chk("hold_cout", 32'(bus.cout), 32'(h_cout));
            chk("hold_ovf", 32'(bus.ovf), 32'(h_ovf));
        end
        held = 1'b0;
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(bus.out_valid), 0);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(bus.sum), 32'(e.sum));
                chk("cout", 32'(bus.cout), 32'(e.cout));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                chk("latency", 32'(cyc - e.t), 32'(int'(STAGES) + stalls - e.st));
                last_sum  = bus.sum;
                last_cout = bus.cout;
                last_ovf  = bus.ovf;
                pops++;
            end
        end else if (bus.out_valid) begin
            held   = 1'b1;
            h_sum  = bus.sum;
            h_cout = bus.cout;
            h_ovf  = bus.ovf;
        end
        if (!exp_rdy) stalls++;
        acc = iv & exp_rdy;
        if (acc) begin
            model(ia, ib, isub, icin, r, co, ov);
            e.sum  = r;
            e.cout = co;
            e.ovf  = ov;
            e.t    = cyc;
            e.st   = stalls;
            q.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, ordy, acc);
    endtask

    // Issue a single op into an empty pipe and wait (bounded) for its result
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
        int   p0;
        logic acc;
        p0 = pops;
        cycle(1'b1, a, b, s, c, 1'b1, acc);
        for (int i = 0; i < 10 && pops == p0; i++) idle(1'b1);
        chk("one_result", 32'(pops - p0), 1);
    endtask

    task automatic do_reset(input int n);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready_during", 32'(bus.in_ready), 1);
        repeat (n) @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        q.delete();
        held = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_in_ready_after", 32'(bus.in_ready), 1);
        chk("rst_w5_out_valid", 32'(bus5.out_valid), 0);
    endtask

    // Single-stage 5-bit build: result one clock after acceptance
    task automatic w5_op(input logic [4:0] a, input logic [4:0] b, input logic s, input logic c,
                         input logic [4:0] es, input logic ec, input logic eo);
        bus5.a        = a;
        bus5.b        = b;
        bus5.sub      = s;
        bus5.cin      = c;
        bus5.in_valid = 1'b1;
        @(negedge clk);
        bus5.in_valid = 1'b0;
        #1;
        chk("w5_valid", 32'(bus5.out_valid), 1);
        chk("w5_sum", 32'(bus5.sum), 32'(es));
        chk("w5_cout", 32'(bus5.cout), 32'(ec));
        chk("w5_ovf", 32'(bus5.ovf), 32'(eo));
        @(negedge clk);
        #1;
        chk("w5_valid_drop", 32'(bus5.out_valid), 0);
    endtask

    initial begin
        logic        acc;
        logic [15:0] ra, rb;
        logic        rs, rc;
        int          p0, left;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.sub        = 1'b0;
        bus.cin        = 1'b0;
        bus.out_ready  = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.a         = '0;
        bus5.b         = '0;
        bus5.sub       = 1'b0;
        bus5.cin       = 1'b0;
        bus5.out_ready = 1'b1;

        do_reset(2);

        w5_op(5'h1F, 5'h1F, 1'b0, 1'b1, 5'h1F, 1'b1, 1'b0);
        w5_op(5'h0F, 5'h01, 1'b0, 1'b0, 5'h10, 1'b0, 1'b1);

        // Directed vectors with hand-derived results
        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            chk($sformatf("vec%0d_sum", i), 32'(last_sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(last_cout), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 32'(last_ovf), 32'(vecs[i].ovf));
        end

        // 8 back-to-back ops at full rate
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
            chk("b2b_accept", 32'(acc), 1);
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
        chk("b2b_count", 32'(pops - p0), 8);

        // Mid-stream stall of 3 cycles with operands still offered
        left = 10;
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        for (int c = 0; c < 14; c++) begin
            cycle(left > 0, ra, rb, rs, rc, !(c >= 6 && c < 9), acc);
            if (acc) begin
                left--;
                ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            end
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
        chk("stall_all_issued", 32'(left), 0);
        chk("stall_drained", 32'(q.size()), 0);

        // Full pipe flushed by a one-cycle reset, then a fresh op
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
        end
        do_reset(1);
        run_one(16'h1234, 16'h4321, 1'b0, 1'b1);
        chk("post_rst_sum", 32'(last_sum), 32'h5556);

        // Random traffic with random bubbles and back-pressure
        ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, ra, rb, rs, rc, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                case ($urandom_range(0, 4))
                    0: ra = 16'hFFFF;
                    1: ra = 16'h8000;
                    default: ra = 16'($urandom);
                endcase
                rb = ($urandom_range(0, 5) == 0) ? 16'h7FFF : 16'($urandom);
                rs = 1'($urandom);
                rc = 1'($urandom);
            end
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        chk("final_drained", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
